// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity-mode
// constants and the bit-timer width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    localparam logic PARITY_EVEN     = 1'b0;
    localparam logic PARITY_ODD_MODE = 1'b1;

    // Width of the bit timer; it only ever holds values up to CLKS_PER_BIT-1.
    function automatic int cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// Synchronous first-word-fall-through FIFO; the head entry is presented
// combinationally and a push into a full FIFO is dropped with an overrun pulse.
module uart_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             overrun,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (level == LW'(DEPTH));
    assign valid   = (level != '0);
    assign rd_data = mem[rd_ptr];
    assign do_pop  = pop && valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push && !do_push;
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver feeding an internal FWFT FIFO drained via valid/ready.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line idle, waiting for a falling edge on rx_s
// START      | timing to mid start bit, rejects false starts
// DATA       | sampling DATA_BITS data bits, LSB first
// PARITY     | sampling and checking the parity bit (parity build only)
// STOP       | sampling STOP_BITS stop bits, pushing the word on success
// WAIT_IDLE  | after an error, waiting for the line to return high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             rx,
    output logic [DATA_BITS-1:0]             m_data,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             busy,
    output logic                             frame_err,
    output logic                             parity_err,
    output logic                             overrun
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BITS_LOAD = BW'(DATA_BITS - 1);
    localparam logic          STOP_LOAD = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks
        $error("uart_rx_fifo: CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
        $error("uart_rx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (PARITY_ODD != int'(PARITY_EVEN) && PARITY_ODD != int'(PARITY_ODD_MODE)) begin : g_bad_par
        $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
    end

    rx_state_t             state;
    logic                  rx_meta;
    logic                  rx_s;
    logic                  rx_prev;
    logic [CW-1:0]         bit_cnt;
    logic [BW-1:0]         bits_left;
    logic                  stop_left;
    logic [DATA_BITS-1:0]  shreg;
    logic                  push_req;
    logic                  tick;

    assign tick = (bit_cnt == '0);
    assign busy = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_MODE = (PARITY_ODD != 0) ? PARITY_ODD_MODE : PARITY_EVEN;
    logic parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            bit_cnt   <= '0;
            bits_left <= '0;
            stop_left <= 1'b0;
            shreg     <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            rx_prev   <= rx_s;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        state   <= ST_START;
                        bit_cnt <= HALF_LOAD;
                    end
                end
                ST_START: begin
                    if (!tick) begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end else if (rx_s) begin
                        state <= ST_IDLE;
                    end else begin
                        state     <= ST_DATA;
                        bit_cnt   <= FULL_LOAD;
                        bits_left <= BITS_LOAD;
                    end
                end
                ST_DATA: begin
                    if (!tick) begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end else begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= FULL_LOAD;
                        if (bits_left == '0) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state     <= ST_STOP;
                            stop_left <= STOP_LOAD;
`endif
                        end else begin
                            bits_left <= bits_left - BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (!tick) begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end else if (rx_s != ((^shreg) ^ PAR_MODE)) begin
                        parity_err_q <= 1'b1;
                        state        <= ST_WAIT_IDLE;
                    end else begin
                        state     <= ST_STOP;
                        bit_cnt   <= FULL_LOAD;
                        stop_left <= STOP_LOAD;
                    end
                end
`endif
                ST_STOP: begin
                    if (!tick) begin
                        bit_cnt <= bit_cnt - CW'(1);
                    end else if (!rx_s) begin
                        frame_err <= 1'b1;
                        state     <= ST_WAIT_IDLE;
                    end else if (!stop_left) begin
                        push_req <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        stop_left <= 1'b0;
                        bit_cnt   <= FULL_LOAD;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_fifo_sync #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (shreg),
        .overrun   (overrun),
        .pop       (m_ready),
        .rd_data   (m_data),
        .valid     (m_valid),
        .level     (level)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo; the parity scenario runs only
// when UART_RX_PARITY_EN is defined (that build uses 7 data bits).
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
    localparam int DB     = 7;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int DB     = 8;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int CLKS  = 8;
    localparam int STOPS = 1;
    localparam int DEPTH = 4;
    localparam bit PODD  = 1'b0;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          m_ready = 1'b0;
    logic [DB-1:0] m_data;
    logic          m_valid;
    logic [LW-1:0] level;
    logic          busy;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    int n_pop = 0, n_valid = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, n_busy = 0;
    logic          busy_q = 1'b0;
    logic [DB-1:0] pop_log [0:255];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CLKS),
        .DATA_BITS    (DB),
        .STOP_BITS    (STOPS),
        .FIFO_DEPTH   (DEPTH),
        .PARITY_ODD   (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .level      (level),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            pop_log[n_pop % 256] = m_data;
            n_pop++;
        end
        if (m_valid)    n_valid++;
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if (overrun)    n_ovr++;
        if (busy && !busy_q) n_busy++;
        busy_q = busy;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        tick(CLKS);
    endtask

    task automatic send_frame(input logic [8:0] data, input bit bad_par, input bit bad_stop);
        logic [8:0] mask;
        mask = (9'h1 << DB) - 9'h1;
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(data[i]);
        if (PAR_EN) drive_bit((^(data & mask)) ^ PODD ^ bad_par);
        for (int i = 0; i < STOPS; i++) drive_bit(!bad_stop);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b busy=%b level=%0d want 0 0 0", m_valid, busy, level);
        end
        checks++;
        if (frame_err !== 1'b0 || parity_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got ferr=%b perr=%b ovr=%b want 0 0 0", frame_err, parity_err, overrun);
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_single_frame();
        int p0, v0, f0, e0, o0;
        p0 = n_pop; v0 = n_valid; f0 = n_ferr; e0 = n_perr; o0 = n_ovr;
        m_ready = 1'b1;
        send_frame(9'h05C, 1'b0, 1'b0);
        tick(2 * CLKS);
        checks++;
        if (n_pop - p0 != 1 || pop_log[p0 % 256] !== DB'(9'h05C)) begin
            errors++;
            $display("FAIL single_data got pops=%0d data=%h want 1 %h", n_pop - p0, pop_log[p0 % 256], DB'(9'h05C));
        end
        checks++;
        if (n_valid - v0 != 1) begin
            errors++;
            $display("FAIL single_valid_cycles got %0d want 1", n_valid - v0);
        end
        checks++;
        if (n_ferr != f0 || n_perr != e0 || n_ovr != o0) begin
            errors++;
            $display("FAIL single_no_errors got ferr=%0d perr=%0d ovr=%0d want 0 0 0", n_ferr - f0, n_perr - e0, n_ovr - o0);
        end
        checks++;
        if (level !== '0) begin
            errors++;
            $display("FAIL single_level got %0d want 0", level);
        end
    endtask

    task automatic test_overrun();
        int p0, o0;
        p0 = n_pop; o0 = n_ovr;
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_frame(9'h05C + 9'(i), 1'b0, 1'b0);
        checks++;
        if (level !== LW'(4) || n_ovr != o0) begin
            errors++;
            $display("FAIL overrun_pre got level=%0d ovr=%0d want 4 0", level, n_ovr - o0);
        end
        send_frame(9'h060, 1'b0, 1'b0);
        tick(CLKS);
        checks++;
        if (level !== LW'(4) || n_ovr - o0 != 1) begin
            errors++;
            $display("FAIL overrun_full got level=%0d ovr=%0d want 4 1", level, n_ovr - o0);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== DB'(9'h05C)) begin
            errors++;
            $display("FAIL overrun_head got valid=%b data=%h want 1 %h", m_valid, m_data, DB'(9'h05C));
        end
        m_ready = 1'b1;
        tick(8);
        checks++;
        if (n_pop - p0 != 4 || level !== '0) begin
            errors++;
            $display("FAIL overrun_drain got pops=%0d level=%0d want 4 0", n_pop - p0, level);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pop_log[(p0 + i) % 256] !== DB'(9'h05C + 9'(i))) begin
                errors++;
                $display("FAIL overrun_order[%0d] got %h want %h", i, pop_log[(p0 + i) % 256], DB'(9'h05C + 9'(i)));
            end
        end
    endtask

    task automatic test_frame_error();
        int p0, f0, e0;
        p0 = n_pop; f0 = n_ferr; e0 = n_perr;
        m_ready = 1'b1;
        send_frame(9'h033, 1'b0, 1'b1);
        tick(2 * CLKS);
        checks++;
        if (n_ferr - f0 != 1 || n_pop != p0 || level !== '0) begin
            errors++;
            $display("FAIL frame_err_pulse got ferr=%0d pops=%0d level=%0d want 1 0 0", n_ferr - f0, n_pop - p0, level);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_busy_low got %b want 1", busy);
        end
        rx = 1'b1;
        tick(4);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_busy_release got %b want 0", busy);
        end
        send_frame(9'h0A5, 1'b0, 1'b0);
        tick(2 * CLKS);
        checks++;
        if (n_pop - p0 != 1 || pop_log[p0 % 256] !== DB'(9'h0A5) || n_ferr - f0 != 1 || n_perr != e0) begin
            errors++;
            $display("FAIL frame_err_recover got pops=%0d data=%h ferr=%0d want 1 %h 1", n_pop - p0, pop_log[p0 % 256], n_ferr - f0, DB'(9'h0A5));
        end
    endtask

    task automatic test_glitch();
        int p0, b0, f0, e0;
        p0 = n_pop; b0 = n_busy; f0 = n_ferr; e0 = n_perr;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2 * CLKS);
        checks++;
        if (n_busy - b0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_busy got rises=%0d busy=%b want 1 0", n_busy - b0, busy);
        end
        checks++;
        if (n_pop != p0 || level !== '0 || n_ferr != f0 || n_perr != e0) begin
            errors++;
            $display("FAIL glitch_no_push got pops=%0d level=%0d ferr=%0d perr=%0d want 0 0 0 0", n_pop - p0, level, n_ferr - f0, n_perr - e0);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int p0, e0;
        p0 = n_pop; e0 = n_perr;
        m_ready = 1'b1;
        send_frame(9'h041, 1'b0, 1'b0);
        tick(2 * CLKS);
        checks++;
        if (n_pop - p0 != 1 || pop_log[p0 % 256] !== DB'(9'h041) || n_perr != e0) begin
            errors++;
            $display("FAIL parity_good got pops=%0d data=%h perr=%0d want 1 41 0", n_pop - p0, pop_log[p0 % 256], n_perr - e0);
        end
        send_frame(9'h041, 1'b1, 1'b0);
        tick(2 * CLKS);
        checks++;
        if (n_pop - p0 != 1 || n_perr - e0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL parity_bad got pops=%0d perr=%0d busy=%b want 1 1 0", n_pop - p0, n_perr - e0, busy);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int p0, f0, e0, o0;
        m_ready = 1'b0;
        send_frame(9'h011, 1'b0, 1'b0);
        send_frame(9'h022, 1'b0, 1'b0);
        tick(CLKS);
        checks++;
        if (level !== LW'(2)) begin
            errors++;
            $display("FAIL mid_reset_prefill got level=%0d want 2", level);
        end
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_busy_before got %b want 1", busy);
        end
        f0 = n_ferr; e0 = n_perr; o0 = n_ovr;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || level !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async got valid=%b level=%0d busy=%b want 0 0 0", m_valid, level, busy);
        end
        tick(2);
        rx = 1'b1;
        rst_n = 1'b1;
        tick(4);
        p0 = n_pop;
        m_ready = 1'b1;
        send_frame(9'h03C, 1'b0, 1'b0);
        tick(2 * CLKS);
        checks++;
        if (n_pop - p0 != 1 || pop_log[p0 % 256] !== DB'(9'h03C)) begin
            errors++;
            $display("FAIL mid_reset_recover got pops=%0d data=%h want 1 %h", n_pop - p0, pop_log[p0 % 256], DB'(9'h03C));
        end
        checks++;
        if (n_ferr != f0 || n_perr != e0 || n_ovr != o0) begin
            errors++;
            $display("FAIL mid_reset_no_errors got ferr=%0d perr=%0d ovr=%0d want 0 0 0", n_ferr - f0, n_perr - e0, n_ovr - o0);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_overrun();
        test_frame_error();
        test_glitch();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
